// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// The op encoding here must match the decoder that drives op.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mdu_abs.sv
// Conditional two's-complement negation.
// It yields the magnitude of signed operands, or applies a recorded sign to a result.
module mdu_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         signed_i,
    input  logic         force_i,
    output logic [W-1:0] mag_o,
    output logic         neg_o
);

    assign neg_o = force_i | (signed_i & val_i[W-1]);
    assign mag_o = neg_o ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO, with MTHI/MTLO done in one cycle.
// It computes on magnitudes, one radix-2 step per cycle, and applies the signs in FIX.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   bop_q;
    logic [CW-1:0]      cnt_q;
    logic               div_q, qsign_q, rsign_q, dz_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               is_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               a_neg, b_neg;

    assign is_signed = (op == OP_MULT) || (op == OP_DIV);

    mdu_abs #(.W(WIDTH)) u_abs_a (
        .val_i(a), .signed_i(is_signed), .force_i(1'b0), .mag_o(a_mag), .neg_o(a_neg)
    );
    mdu_abs #(.W(WIDTH)) u_abs_b (
        .val_i(b), .signed_i(is_signed), .force_i(1'b0), .mag_o(b_mag), .neg_o(b_neg)
    );

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] step_acc;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? bop_q : {WIDTH{1'b0}})};
        div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, bop_q};
        step_acc  = {mul_sum, acc_q[WIDTH-1:1]};
        if (div_q) begin
            if (!div_trial[WIDTH])
                step_acc = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                step_acc = {acc_q[2*WIDTH-2:0], 1'b0};
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic [2:0]         fix_neg_unused;

    mdu_abs #(.W(2*WIDTH)) u_neg_prod (
        .val_i(acc_q), .signed_i(1'b0), .force_i(qsign_q),
        .mag_o(prod_fix), .neg_o(fix_neg_unused[0])
    );
    mdu_abs #(.W(WIDTH)) u_neg_quot (
        .val_i(acc_q[WIDTH-1:0]), .signed_i(1'b0), .force_i(qsign_q),
        .mag_o(quot_fix), .neg_o(fix_neg_unused[1])
    );
    mdu_abs #(.W(WIDTH)) u_neg_rem (
        .val_i(acc_q[2*WIDTH-1:WIDTH]), .signed_i(1'b0), .force_i(rsign_q),
        .mag_o(rem_fix), .neg_o(fix_neg_unused[2])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            bop_q   <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: hi_q <= a;
                            OP_MTLO: lo_q <= a;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                acc_q   <= {{WIDTH{1'b0}}, a_mag};
                                bop_q   <= b_mag;
                                div_q   <= (op == OP_DIV) || (op == OP_DIVU);
                                qsign_q <= a_neg ^ b_neg;
                                rsign_q <= a_neg;
                                dz_q    <= (b == '0);
                                cnt_q   <= '0;
                                busy_q  <= 1'b1;
                                state_q <= S_RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    acc_q <= step_acc;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1))
                        state_q <= S_FIX;
                end
                S_FIX: begin
                    if (div_q) begin
                        // Divide by zero leaves remainder = a naturally; only the quotient is forced.
                        lo_q <= dz_q ? {WIDTH{1'b1}} : quot_fix;
                        hi_q <= rem_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: a vector table of MDU ops plus hand-written
// sequences for reset, MTHI/MTLO and starts that arrive while the unit is busy.
module tb_mdu_iterative;
    import mdu_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       op = 3'd0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy, done;
    logic [WIDTH-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mdu_iterative #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one iterative op; optionally inject an MTLO start at run cycle inj.
    task automatic run_op(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] ehi, input logic [31:0] elo, input int inj);
        logic [31:0] hi0, lo0;
        bit bad;
        @(negedge clk);
        op = o; a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
        chk("busy_after_E0", {63'd0, busy}, 64'd1);
        hi0 = hi; lo0 = lo; bad = 1'b0;
        for (int k = 1; k <= WIDTH + 1; k++) begin
            if (k == inj) begin
                @(negedge clk);
                start = 1'b1; op = OP_MTLO; a = 32'h55;
            end
            @(posedge clk); #1;
            if (k == inj) begin
                start = 1'b0; a = $urandom;
            end
            if (k <= WIDTH && (!busy || done || hi !== hi0 || lo !== lo0)) bad = 1'b1;
        end
        chk("run_window_clean", {63'd0, bad}, 64'd0);
        chk("done_at_E33", {63'd0, done}, 64'd1);
        chk("busy_clear_E33", {63'd0, busy}, 64'd0);
        chk("hi_result", {32'd0, hi}, {32'd0, ehi});
        chk("lo_result", {32'd0, lo}, {32'd0, elo});
        @(posedge clk); #1;
        chk("done_one_pulse", {63'd0, done}, 64'd0);
    endtask

    initial begin
        vt[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vt[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vt[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vt[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vt[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vt[5]  = '{OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
        vt[6]  = '{OP_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E};
        vt[7]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vt[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vt[9]  = '{OP_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF};
        vt[10] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vt[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_done", {63'd0, done}, 64'd0);

        for (int i = 0; i < 12; i++)
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].ehi, vt[i].elo, 0);

        // MTHI then MTLO on consecutive edges
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; a = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("mthi_hi", {32'd0, hi}, 64'h00000000DEADBEEF);
        chk("mthi_busy", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        op = OP_MTLO; a = 32'h12345678;
        @(posedge clk); #1;
        chk("mtlo_lo", {32'd0, lo}, 64'h0000000012345678);
        chk("mtlo_hi_kept", {32'd0, hi}, 64'h00000000DEADBEEF);
        chk("mtlo_busy", {62'd0, busy, done}, 64'd0);
        start = 1'b0;
        @(posedge clk); #1;
        chk("mt_after_busy", {62'd0, busy, done}, 64'd0);

        // Start during busy is ignored
        run_op(OP_DIVU, 32'hFFFFFFFF, 32'd10, 32'h00000005, 32'h19999999, 5);

        // Codes 6 and 7 are no-ops
        @(negedge clk);
        start = 1'b1; op = 3'd6; a = 32'hAAAA5555;
        @(posedge clk); #1;
        op = 3'd7;
        @(posedge clk); #1;
        start = 1'b0;
        chk("noop_busy", {62'd0, busy, done}, 64'd0);
        chk("noop_hilo", {hi, lo}, {32'h00000005, 32'h19999999});

        // Reset mid-RUN
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; a = 32'h12345678; b = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", {32'd0, hi}, 64'd0);
        chk("midrst_lo", {32'd0, lo}, 64'd0);
        chk("midrst_busy", {62'd0, busy, done}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", {62'd0, busy, done}, 64'd0);
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Multi-cycle multiply/divide unit in the EX stage; owns the HI/LO registers.
- Operands a and b arrive from the EX-stage forwarding operand muxes (2:1 32-bit select, sel ? a : b).
- Executes MULT/MULTU/DIV/DIVU iteratively and MTHI/MTLO in one cycle.
- busy goes to the hazard unit to stall MFHI/MFLO and further MDU ops.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on clk rising edge
- op  input  3  operation, encoded per mdu_pkg
- a  input  WIDTH  rs operand, from the forwarding mux
- b  input  WIDTH  rt operand, from the forwarding mux
- busy  output  1  iterative operation in progress
- done  output  1  one-cycle pulse when hi/lo are updated by MULT/DIV
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, rst_n=0): hi=0, lo=0, busy=0, done=0, FSM=IDLE; all internal state cleared.
- Reset mid-operation aborts the operation; hi/lo still go to 0.
- Op codes: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5. Codes 6-7 are no-ops.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - start=1 with MTHI: hi<=a on that edge; busy stays 0; no done.
  - start=1 with MTLO: lo<=a on that edge; busy stays 0; no done.
  - start=1 with MULT/MULTU/DIV/DIVU: latch operands and op; counter<=0; go to RUN.
- Signed ops: operands are converted to magnitudes on capture; result signs are recorded.
  - MULT product sign = a[31]^b[31].
  - DIV quotient sign = a[31]^b[31]; remainder sign = a[31].
- RUN: one radix-2 step per cycle for exactly WIDTH cycles.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring, 1 quotient bit per cycle.
  - After step WIDTH-1, go to FIX.
- FIX: apply sign correction; write hi/lo; done=1 for this edge's cycle; return to IDLE.
- Timing: start accepted at edge E0.
  - busy=1 from after E0 until after E(WIDTH+1), i.e. 33 cycles for WIDTH=32.
  - hi/lo update and done rise at E(WIDTH+1).
- Results:
  - Multiply: {hi,lo} = full 2*WIDTH product.
  - Divide: lo = quotient, hi = remainder.
- Divide by zero (b=0, DIV or DIVU): lo = all ones, hi = a. Same latency, no exception.
- Signed overflow (DIV, a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0.
- start while busy=1 is ignored. The hazard unit guarantees no issue; the bench checks this anyway.
- hi/lo are never partially updated; they hold their old values throughout RUN.
- Operand changes on a/b after E0 have no effect.

Decomposition:
- mdu_pkg holds:
  - op code localparams (OP_MULT..OP_MTLO)
  - FSM state encoding (S_IDLE, S_RUN, S_FIX)
  - default WIDTH
- One sub-module: mdu_abs, combinational two's-complement magnitude plus sign bit.
  - Instantiated twice, for the a and b captures.
  - Also reused for result negation in FIX.

Test Plan:
- Reset then idle -> hi=0, lo=0, busy=0, done=0. Assert rst_n=0 mid-RUN -> outputs 0 immediately, FSM in IDLE.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 33 cycles, done at E33, hi=0xFFFFFFFE, lo=0x00000001. MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234.
- MTHI a=0xDEADBEEF, then MTLO a=0x12345678 on consecutive cycles -> hi/lo updated on each edge, busy never asserted, done never asserted.
- During a DIVU (busy=1): pulse start with MTLO a=0x55 and randomize a/b -> ignored; final results equal those for the original operands.
